mem_bus_arbiter: RTL and testbench

- Shares one unified 16-bit memory bus between the CPU instruction-fetch port and the CPU data port.
- Arbitrates stb/ack requests from the two ports and sequences one downstream transaction at a time.
- Registers read data and returns ack/err to the granted requester.
- Sits between the CPU core's instr_*/data_* buses and the single memory or peripheral slave.

---
 rtl/cpu_bus_pkg.sv | 8 +
 rtl/bus_arb_pri.sv | 29 ++
 rtl/mem_bus_arbiter.sv | 92 +++++++++
 tb/tb_mem_bus_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared state encoding, grant codes and default widths for the memory bus arbiter
package cpu_bus_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;
   localparam logic GNT_INSTR = 1'b0;
   localparam logic GNT_DATA = 1'b1;
   localparam int DEF_AW = 16;
   localparam int DEF_DW = 16;
endpackage

// File: rtl/bus_arb_pri.sv
// bus_arb_pri: data-first grant decision with starvation guard for the instruction port
module bus_arb_pri
   import cpu_bus_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic grant_en,
   input  logic instr_stb,
   input  logic data_stb,
   output logic gnt_valid,
   output logic gnt_sel
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] starve_cnt;
   logic starved;
   // data wins ties unless instr has already lost STARVE_LIMIT times in a row
   always_comb begin
      starved = starve_cnt == SW'(STARVE_LIMIT);
      gnt_valid = grant_en && (instr_stb || data_stb);
      gnt_sel = data_stb && !(instr_stb && starved) ? GNT_DATA : GNT_INSTR;
   end
   // count data grants taken over a waiting instr request, saturating at the limit
   always_ff @(posedge sys_clk) begin
      if (!sys_rst) starve_cnt <= '0;
      else if (gnt_valid) starve_cnt <= gnt_sel == GNT_INSTR ? '0 : (instr_stb && !starved) ? starve_cnt + 1'b1 : starve_cnt;
   end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between the instruction and data ports, one transaction at a time
module mem_bus_arbiter
   import cpu_bus_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   input  logic          instr_stb_i,
   input  logic          instr_we_i,
   input  logic [AW-1:0] instr_addr_i,
   input  logic [DW-1:0] instr_data_i,
   output logic [DW-1:0] instr_data_o,
   output logic          instr_ack_o,
   output logic          instr_err_o,
   input  logic          data_stb_i,
   input  logic          data_we_i,
   input  logic [AW-1:0] data_addr_i,
   input  logic [DW-1:0] data_data_i,
   output logic [DW-1:0] data_data_o,
   output logic          data_ack_o,
   output logic          data_err_o,
   output logic          mem_stb_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_data_o,
   input  logic [DW-1:0] mem_data_i,
   input  logic          mem_ack_i
);
   state_t state, nxt;
   logic sel, err, gnt_valid, gnt_sel, tmo_done, done, capture;
   logic [7:0] tmo_cnt;
   logic [DW-1:0] rdata;

   bus_arb_pri #(.STARVE_LIMIT(STARVE_LIMIT)) u_pri (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .grant_en (state == IDLE),
      .instr_stb(instr_stb_i),
      .data_stb (data_stb_i),
      .gnt_valid(gnt_valid),
      .gnt_sel  (gnt_sel)
   );

   // next state plus bus/response outputs decoded from state; an ack in the timeout cycle still counts as success
   always_comb begin
      tmo_done = tmo_cnt == 8'(TIMEOUT_CYC - 1);
      done = state == BUS && (mem_ack_i || tmo_done);
      capture = done && (!mem_ack_i || !mem_we_o);
      rdata = mem_ack_i ? mem_data_i : '0;
      nxt = state == IDLE ? (gnt_valid ? BUS : IDLE) : state == BUS ? (done ? RESP : BUS) : IDLE;
      mem_stb_o = state == BUS;
      instr_ack_o = state == RESP && sel == GNT_INSTR;
      data_ack_o = state == RESP && sel == GNT_DATA;
      instr_err_o = instr_ack_o && err;
      data_err_o = data_ack_o && err;
   end

   // state register; reset returns to IDLE so any late mem_ack_i is ignored
   always_ff @(posedge sys_clk) begin
      if (!sys_rst) state <= IDLE;
      else state <= nxt;
   end

   // latch the granted request, run the timeout counter and capture read data or the timeout zero
   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         sel <= GNT_INSTR;
         err <= 1'b0;
         tmo_cnt <= '0;
         mem_we_o <= 1'b0;
         mem_addr_o <= '0;
         mem_data_o <= '0;
         instr_data_o <= '0;
         data_data_o <= '0;
      end else begin
         tmo_cnt <= state == BUS ? tmo_cnt + 8'd1 : 8'd0;
         if (gnt_valid) begin
            sel <= gnt_sel;
            mem_we_o <= gnt_sel == GNT_DATA ? data_we_i : instr_we_i;
            mem_addr_o <= gnt_sel == GNT_DATA ? data_addr_i : instr_addr_i;
            mem_data_o <= gnt_sel == GNT_DATA ? data_data_i : instr_data_i;
         end
         if (done) err <= !mem_ack_i;
         if (capture && sel == GNT_INSTR) instr_data_o <= rdata;
         if (capture && sel == GNT_DATA) data_data_o <= rdata;
      end
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scoreboard bench for the shared memory bus arbiter
module tb_mem_bus_arbiter;
   logic sys_clk, sys_rst;
   logic instr_stb_i, instr_we_i, data_stb_i, data_we_i, mem_ack_i;
   logic [15:0] instr_addr_i, instr_data_i, data_addr_i, data_data_i, mem_data_i;
   logic [15:0] instr_data_o, data_data_o, mem_addr_o, mem_data_o;
   logic instr_ack_o, instr_err_o, data_ack_o, data_err_o, mem_stb_o, mem_we_o;

   typedef struct {
      bit port;
      logic [15:0] data;
      bit err;
   } exp_t;
   exp_t sb[$];
   int checks = 0;
   int failures = 0;

   mem_bus_arbiter dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .instr_stb_i(instr_stb_i), .instr_we_i(instr_we_i), .instr_addr_i(instr_addr_i),
      .instr_data_i(instr_data_i), .instr_data_o(instr_data_o), .instr_ack_o(instr_ack_o), .instr_err_o(instr_err_o),
      .data_stb_i(data_stb_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
      .data_data_i(data_data_i), .data_data_o(data_data_o), .data_ack_o(data_ack_o), .data_err_o(data_err_o),
      .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic wait_stb(input string tag);
      int n = 0;
      while (!mem_stb_o && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_stb_rise"}, mem_stb_o, 1);
   endtask

   // wait for the bus request, check it, then ack after delay cycles with read data rd
   task automatic serve(input string tag, input int delay, input logic [15:0] rd,
                        input logic we, input logic [15:0] addr, input logic [15:0] wdata);
      wait_stb(tag);
      chk({tag, "_bus_req"}, {mem_we_o, mem_addr_o, mem_data_o}, {we, addr, wdata});
      repeat (delay) step();
      chk({tag, "_stb_at_ack"}, mem_stb_o, 1);
      mem_data_i = rd;
      mem_ack_i = 1'b1;
      step();
      mem_ack_i = 1'b0;
   endtask

   // called in the response cycle: pop the oldest expectation and compare ack/err/data
   task automatic collect(input string tag);
      exp_t e;
      chk({tag, "_pending"}, sb.size() != 0, 1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_ack"}, {instr_ack_o, data_ack_o}, e.port ? 2'b01 : 2'b10);
         chk({tag, "_err"}, {instr_err_o, data_err_o}, e.port ? {1'b0, e.err} : {e.err, 1'b0});
         chk({tag, "_rdata"}, e.port ? data_data_o : instr_data_o, e.data);
      end
   endtask

   initial begin
      int cnt;
      exp_t e;
      sys_rst = 1'b0;
      {instr_stb_i, instr_we_i, data_stb_i, data_we_i, mem_ack_i} = '0;
      {instr_addr_i, instr_data_i, data_addr_i, data_data_i, mem_data_i} = '0;
      repeat (3) step();
      chk("reset_outs", {mem_stb_o, mem_we_o, mem_addr_o, mem_data_o, instr_ack_o, instr_err_o, data_ack_o, data_err_o},
          '0);
      chk("reset_rdata", {instr_data_o, data_data_o}, '0);
      sys_rst = 1'b1;
      step();

      // single data read
      data_stb_i = 1'b1; data_we_i = 1'b0; data_addr_i = 16'h0040; data_data_i = 16'h0000;
      e = '{1'b1, 16'hBEEF, 1'b0}; sb.push_back(e);
      serve("rd", 1, 16'hBEEF, 1'b0, 16'h0040, 16'h0000);
      collect("rd");
      data_stb_i = 1'b0;
      step();
      chk("rd_ack_pulse", {instr_ack_o, data_ack_o, mem_stb_o}, 3'b000);

      // data write leaves data_data_o at the last read value
      data_stb_i = 1'b1; data_we_i = 1'b1; data_addr_i = 16'h0100; data_data_i = 16'h1234;
      e = '{1'b1, 16'hBEEF, 1'b0}; sb.push_back(e);
      serve("wr", 1, 16'hDEAD, 1'b1, 16'h0100, 16'h1234);
      collect("wr");
      data_stb_i = 1'b0; data_we_i = 1'b0; data_data_i = 16'h0000;
      step();

      // both ports continuously requesting: D,D,D,D,I repeating
      instr_stb_i = 1'b1; instr_addr_i = 16'h2000;
      data_stb_i = 1'b1; data_addr_i = 16'h3000;
      for (int i = 0; i < 10; i++) begin
         e.port = (i % 5) != 4;
         e.data = 16'hA000 + 16'(i);
         e.err = 1'b0;
         sb.push_back(e);
         serve($sformatf("starve%0d", i), 0, 16'hA000 + 16'(i), 1'b0, e.port ? 16'h3000 : 16'h2000, 16'h0000);
         collect($sformatf("starve%0d", i));
      end
      instr_stb_i = 1'b0; data_stb_i = 1'b0;
      step();

      // single instruction read
      instr_stb_i = 1'b1; instr_addr_i = 16'h0500;
      e = '{1'b0, 16'h7777, 1'b0}; sb.push_back(e);
      serve("ird", 2, 16'h7777, 1'b0, 16'h0500, 16'h0000);
      collect("ird");
      instr_stb_i = 1'b0;
      step();

      // timeout: slave never acks
      data_stb_i = 1'b1; data_addr_i = 16'h0200;
      e = '{1'b1, 16'h0000, 1'b1}; sb.push_back(e);
      wait_stb("tmo");
      cnt = 0;
      while (mem_stb_o && cnt < 400) begin
         cnt++;
         step();
      end
      chk("tmo_stb_cycles", cnt, 255);
      collect("tmo");
      data_stb_i = 1'b0;
      step();
      data_stb_i = 1'b1; data_addr_i = 16'h0202;
      e = '{1'b1, 16'h5A5A, 1'b0}; sb.push_back(e);
      serve("after_tmo", 1, 16'h5A5A, 1'b0, 16'h0202, 16'h0000);
      collect("after_tmo");
      data_stb_i = 1'b0;
      step();

      // ack arrives in the last BUS cycle: ack wins over timeout
      data_stb_i = 1'b1; data_addr_i = 16'h0300;
      e = '{1'b1, 16'hC0DE, 1'b0}; sb.push_back(e);
      serve("coll", 254, 16'hC0DE, 1'b0, 16'h0300, 16'h0000);
      collect("coll");
      data_stb_i = 1'b0;
      step();

      // reset in the middle of a bus cycle, late ack discarded
      instr_stb_i = 1'b1; instr_addr_i = 16'h0600;
      wait_stb("mid_rst");
      sys_rst = 1'b0;
      step();
      chk("mid_rst_outs", {mem_stb_o, mem_we_o, mem_addr_o, mem_data_o, instr_ack_o, instr_err_o, data_ack_o, data_err_o},
          '0);
      chk("mid_rst_rdata", {instr_data_o, data_data_o}, '0);
      sys_rst = 1'b1; instr_stb_i = 1'b0;
      mem_data_i = 16'h9999; mem_ack_i = 1'b1;
      step();
      mem_ack_i = 1'b0;
      chk("late_ack_ignored", {instr_ack_o, data_ack_o, mem_stb_o, instr_data_o}, '0);
      step();
      chk("late_ack_idle", {instr_ack_o, data_ack_o, mem_stb_o}, 3'b000);
      chk("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
